// File: rtl/pc_sequencer_pkg.sv
// Shared processor definitions used by the fetch path: PC width, reset vector
// and the sequencer state encoding.
package pc_sequencer_pkg;

    localparam int PC_WIDTH = 8;
    localparam logic [PC_WIDTH-1:0] RESET_VECTOR_DEF = 8'h00;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_HOLD   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_HALTED = 3'd4
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer.sv
// Fetch sequencer: loads the PC register, reads instruction bytes at PCOut,
// presents them to the control unit and computes the next PC.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_INIT   | write RESET_VECTOR into the PC register
// ST_FETCH  | MemRead high at PCOut, wait for MemReady
// ST_HOLD   | Instr valid, wait for accept (or Halt)
// ST_UPDATE | write sequential/branch next PC
// ST_HALTED | stopped until Reset
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] PCOut,
    output logic [WIDTH-1:0] PCIn,
    output logic             PCWrite,
    output logic [WIDTH-1:0] MemAddr,
    output logic             MemRead,
    input  logic [WIDTH-1:0] MemData,
    input  logic             MemReady,
    output logic [WIDTH-1:0] Instr,
    output logic             InstrValid,
    input  logic             InstrAccept,
    input  logic             Branch,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Halt,
    output logic             Halted
);

    seq_state_e       state;
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] next_pc;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= ST_INIT;
            instr_q <= '0;
            next_pc <= RESET_VECTOR;
        end else begin
            case (state)
                ST_INIT: state <= ST_FETCH;
                ST_FETCH: begin
                    if (MemReady) begin
                        instr_q <= MemData;
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Halt takes priority over a simultaneous accept
                    if (Halt) begin
                        state <= ST_HALTED;
                    end else if (InstrAccept) begin
                        next_pc <= Branch ? BranchTarget : PCOut + WIDTH'(1);
                        state   <= ST_UPDATE;
                    end
                end
                ST_UPDATE: state <= ST_FETCH;
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_INIT;
            endcase
        end
    end

    // Strobes decode straight from the state register; Reset masks them so
    // nothing is requested while the sequencer is held in reset.
    assign PCWrite    = !Reset && ((state == ST_INIT) || (state == ST_UPDATE));
    assign MemRead    = !Reset && (state == ST_FETCH);
    assign InstrValid = !Reset && (state == ST_HOLD);
    assign Halted     = !Reset && (state == ST_HALTED);

    // next_pc holds RESET_VECTOR through INIT and the last computed PC after,
    // so PCIn keeps its last driven value and PCWrite alone qualifies it.
    assign PCIn    = next_pc;
    assign MemAddr = PCOut;
    assign Instr   = instr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: pc_sequencer with a behavioural PC register and an
// instruction memory (byte = address) with per-address wait states.
module tb_pc_sequencer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] PCOut = 8'h5A;
    logic [7:0] PCIn;
    logic       PCWrite;
    logic [7:0] MemAddr;
    logic       MemRead;
    logic [7:0] MemData;
    logic       MemReady;
    logic [7:0] Instr;
    logic       InstrValid;
    logic       InstrAccept = 1'b0;
    logic       Branch = 1'b0;
    logic [7:0] BranchTarget = 8'h00;
    logic       Halt = 1'b0;
    logic       Halted;

    int n_vec = 0;
    int n_miscmp = 0;

    pc_sequencer dut (
        .Clock(Clock), .Reset(Reset), .PCOut(PCOut), .PCIn(PCIn),
        .PCWrite(PCWrite), .MemAddr(MemAddr), .MemRead(MemRead),
        .MemData(MemData), .MemReady(MemReady), .Instr(Instr),
        .InstrValid(InstrValid), .InstrAccept(InstrAccept), .Branch(Branch),
        .BranchTarget(BranchTarget), .Halt(Halt), .Halted(Halted)
    );

    always #5 Clock = ~Clock;

    // PC register: captures on posedge, output moves at the following negedge
    logic       wr_pend = 1'b0;
    logic [7:0] pc_pend = 8'h00;
    int         pcw_count = 0;
    always @(posedge Clock) begin
        wr_pend <= PCWrite;
        pc_pend <= PCIn;
        if (PCWrite) pcw_count <= pcw_count + 1;
    end
    always @(negedge Clock) if (wr_pend) PCOut <= pc_pend;

    // Memory: contents equal the address; wait states per address
    function automatic int wait_for(input logic [7:0] a);
        case (a)
            8'h05:   return 2;
            8'h33:   return 1000;
            default: return 0;
        endcase
    endfunction

    int wcnt = 0;
    always @(posedge Clock) begin
        if (MemRead && !MemReady) wcnt <= wcnt + 1;
        else                      wcnt <= 0;
    end
    assign MemReady = MemRead && (wcnt >= wait_for(MemAddr));
    assign MemData  = MemAddr;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
        #1;
    endtask

    // Entered in the first FETCH cycle; leaves in the HOLD cycle
    task automatic fetch_wait(input logic [7:0] addr, input int waits);
        int n = 0;
        chk("fetch_addr", MemAddr, addr);
        while (InstrValid !== 1'b1 && n < 20) begin
            chk("fetch_memread", {7'd0, MemRead}, 8'd1);
            step();
            n++;
        end
        chk("fetch_cycles", 8'(n), 8'(waits + 1));
        chk("hold_valid", {7'd0, InstrValid}, 8'd1);
        chk("hold_instr", Instr, addr);
        chk("hold_memread", {7'd0, MemRead}, 8'd0);
    endtask

    // Entered in HOLD; leaves in the next FETCH cycle
    task automatic accept(input int delay, input logic br, input logic [7:0] tgt,
                          input logic [7:0] exp_next);
        repeat (delay) begin
            step();
            chk("hold_stay", {7'd0, InstrValid}, 8'd1);
            chk("hold_nowrite", {7'd0, PCWrite}, 8'd0);
        end
        InstrAccept  = 1'b1;
        Branch       = br;
        BranchTarget = tgt;
        step();
        InstrAccept = 1'b0;
        Branch      = 1'b0;
        chk("upd_pcwrite", {7'd0, PCWrite}, 8'd1);
        chk("upd_pcin", PCIn, exp_next);
        chk("upd_valid", {7'd0, InstrValid}, 8'd0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pcw0;
        repeat (3) step();
        chk("rst_pcwrite", {7'd0, PCWrite}, 8'd0);
        chk("rst_memread", {7'd0, MemRead}, 8'd0);
        chk("rst_valid", {7'd0, InstrValid}, 8'd0);
        chk("rst_halted", {7'd0, Halted}, 8'd0);
        chk("rst_instr", Instr, 8'h00);
        chk("rst_pcin", PCIn, 8'h00);

        Reset = 1'b0;
        #1;
        chk("init_pcwrite", {7'd0, PCWrite}, 8'd1);
        chk("init_pcin", PCIn, 8'h00);
        step();

        fetch_wait(8'h00, 0); accept(0, 1'b0, 8'h00, 8'h01);
        fetch_wait(8'h01, 0); accept(0, 1'b0, 8'h00, 8'h02);
        fetch_wait(8'h02, 0); accept(2, 1'b0, 8'h00, 8'h03);
        fetch_wait(8'h03, 0); accept(0, 1'b0, 8'h00, 8'h04);
        fetch_wait(8'h04, 0); accept(0, 1'b0, 8'h00, 8'h05);
        fetch_wait(8'h05, 2); accept(0, 1'b0, 8'h00, 8'h06);
        fetch_wait(8'h06, 0); accept(0, 1'b1, 8'h10, 8'h10);
        fetch_wait(8'h10, 0); accept(0, 1'b1, 8'hA0, 8'hA0);
        fetch_wait(8'hA0, 0); accept(0, 1'b1, 8'hFF, 8'hFF);
        fetch_wait(8'hFF, 0); accept(0, 1'b0, 8'h55, 8'h00);
        fetch_wait(8'h00, 0); accept(0, 1'b1, 8'h33, 8'h33);

        // Stalled fetch at 0x33 interrupted by a one-cycle Reset
        chk("stall_addr", MemAddr, 8'h33);
        repeat (3) begin
            step();
            chk("stall_memread", {7'd0, MemRead}, 8'd1);
            chk("stall_valid", {7'd0, InstrValid}, 8'd0);
        end
        Reset = 1'b1;
        step();
        chk("rst2_valid", {7'd0, InstrValid}, 8'd0);
        chk("rst2_memread", {7'd0, MemRead}, 8'd0);
        chk("rst2_pcwrite", {7'd0, PCWrite}, 8'd0);
        chk("rst2_instr", Instr, 8'h00);
        Reset = 1'b0;
        #1;
        chk("rst2_init_pcwrite", {7'd0, PCWrite}, 8'd1);
        chk("rst2_init_pcin", PCIn, 8'h00);
        step();
        fetch_wait(8'h00, 0); accept(0, 1'b0, 8'h00, 8'h01);
        fetch_wait(8'h01, 0);

        // Halt and accept together: Halt wins, no PC write
        pcw0 = pcw_count;
        Halt        = 1'b1;
        InstrAccept = 1'b1;
        step();
        Halt        = 1'b0;
        InstrAccept = 1'b0;
        chk("halt_halted", {7'd0, Halted}, 8'd1);
        chk("halt_pcwrite", {7'd0, PCWrite}, 8'd0);
        chk("halt_valid", {7'd0, InstrValid}, 8'd0);
        chk("halt_instr", Instr, 8'h01);
        repeat (12) begin
            step();
            chk("halt_memread", {7'd0, MemRead}, 8'd0);
        end
        chk("halt_still", {7'd0, Halted}, 8'd1);
        chk("halt_no_pcw", 8'(pcw_count - pcw0), 8'd0);
        chk("halt_pcout", PCOut, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
